ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_ckpt.sv | 170 +++++++++++++++++
 tb/tb_ras_ckpt.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with checkpoint save/restore for recovery
// after a branch misprediction.
// Circular buffer indexed by a top-of-stack pointer. The depth counter
// saturates at DEPTH, and a push onto a full stack overwrites the oldest
// entry.
// Optional feature: define RAS_LAST_POP_EN to keep a last-popped register.
// A pop on an empty stack then returns that register instead of zero.
module ras_ckpt #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NCKPT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dout,
    output logic                       pop_hit,
    input  logic                       ckpt_save,
    input  logic [$clog2(NCKPT)-1:0]   ckpt_save_tag,
    input  logic                       ckpt_restore,
    input  logic [$clog2(NCKPT)-1:0]   ckpt_restore_tag,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;

    localparam logic [AW-1:0] TOS_RST = AW'(DEPTH - 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    // Architectural stack state
    logic [AW-1:0]    tos_q, tos_n;
    logic [DW-1:0]    depth_q, depth_n;
    logic [WIDTH-1:0] mem [DEPTH];

    // Checkpoint slots
    logic [AW-1:0]    ck_tos   [NCKPT];
    logic [DW-1:0]    ck_depth [NCKPT];
    logic [WIDTH-1:0] ck_val   [NCKPT];

    // Memory write port (one write per cycle: push or restore)
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    // Checkpoint write request
    logic             ck_we;
    logic [WIDTH-1:0] ck_top;

    // Value returned by a pop on an empty stack
    logic [WIDTH-1:0] empty_pop_val;

    logic is_empty, is_full;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_MAX);

    assign depth = depth_q;
    assign full  = is_full;
    assign empty = is_empty;

`ifdef RAS_LAST_POP_EN
    logic [WIDTH-1:0] last_pop_q;

    // Remember the most recent successful pop (not checkpointed)
    always_ff @(posedge clk) begin
        if (reset) begin
            last_pop_q <= '0;
        end else if (pop_hit) begin
            last_pop_q <= pop_dout;
        end
    end

    assign empty_pop_val = last_pop_q;
`else
    assign empty_pop_val = '0;
`endif

    // Next-state, memory write, checkpoint capture and pop outputs
    always_comb begin
        tos_n     = tos_q;
        depth_n   = depth_q;
        mem_we    = 1'b0;
        mem_waddr = tos_q;
        mem_wdata = push_din;
        ck_we     = 1'b0;
        ck_top    = '0;
        pop_hit   = 1'b0;
        pop_dout  = '0;

        if (reset) begin
            // Reset wins; the state registers are cleared in the sequential block
            mem_we = 1'b0;
        end else if (ckpt_restore) begin
            // Restore overrides push, pop and save in the same cycle
            tos_n     = ck_tos[ckpt_restore_tag];
            depth_n   = ck_depth[ckpt_restore_tag];
            mem_we    = 1'b1;
            mem_waddr = ck_tos[ckpt_restore_tag];
            mem_wdata = ck_val[ckpt_restore_tag];
        end else begin
            if (pop) begin
                if (!is_empty) begin
                    pop_hit  = 1'b1;
                    pop_dout = mem[tos_q];
                end else begin
                    pop_dout = empty_pop_val;
                end
            end

            if (push && pop && !is_empty) begin
                // Replace the top in place; tos and depth are unchanged
                mem_we    = 1'b1;
                mem_waddr = tos_q;
            end else if (push) begin
                tos_n     = tos_q + AW'(1);
                mem_we    = 1'b1;
                mem_waddr = tos_q + AW'(1);
                if (!is_full) begin
                    depth_n = depth_q + DW'(1);
                end
            end else if (pop && !is_empty) begin
                tos_n   = tos_q - AW'(1);
                depth_n = depth_q - DW'(1);
            end

            // The snapshot reflects the post-update state of this cycle
            ck_we  = ckpt_save;
            ck_top = push ? push_din : mem[tos_n];
        end
    end

    // Pointer and depth registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q   <= TOS_RST;
            depth_q <= '0;
        end else begin
            tos_q   <= tos_n;
            depth_q <= depth_n;
        end
    end

    // Stack storage; contents are left unreset since they are unobservable at depth 0
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Checkpoint slot storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NCKPT); i++) begin
                ck_tos[i]   <= TOS_RST;
                ck_depth[i] <= '0;
                ck_val[i]   <= '0;
            end
        end else if (ck_we) begin
            ck_tos[ckpt_save_tag]   <= tos_n;
            ck_depth[ckpt_save_tag] <= depth_n;
            ck_val[ckpt_save_tag]   <= ck_top;
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt (DEPTH=4, NCKPT=4, WIDTH=32).
// Directed scenarios are followed by randomized traffic. Both are checked
// against a behavioural model that holds an indexed array, a pointer and a
// depth count.
module tb_ras_ckpt;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned NC = 4;

`ifdef RAS_LAST_POP_EN
    localparam bit LAST_POP = 1'b1;
`else
    localparam bit LAST_POP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic [W-1:0]  push_din = '0;
    logic          pop = 1'b0;
    logic [W-1:0]  pop_dout;
    logic          pop_hit;
    logic          ckpt_save = 1'b0;
    logic [1:0]    ckpt_save_tag = '0;
    logic          ckpt_restore = 1'b0;
    logic [1:0]    ckpt_restore_tag = '0;
    logic [2:0]    depth;
    logic          full;
    logic          empty;

    ras_ckpt #(.WIDTH(W), .DEPTH(D), .NCKPT(NC)) dut (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .push_din         (push_din),
        .pop              (pop),
        .pop_dout         (pop_dout),
        .pop_hit          (pop_hit),
        .ckpt_save        (ckpt_save),
        .ckpt_save_tag    (ckpt_save_tag),
        .ckpt_restore     (ckpt_restore),
        .ckpt_restore_tag (ckpt_restore_tag),
        .depth            (depth),
        .full             (full),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_mem [D];
    int           m_tos;
    int           m_depth;
    logic [W-1:0] m_last;
    int           s_tos   [NC];
    int           s_depth [NC];
    logic [W-1:0] s_val   [NC];

    // Pop outputs seen in the most recent step
    logic [W-1:0] obs_dout;
    logic         obs_hit;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tos   = D - 1;
        m_depth = 0;
        m_last  = '0;
        for (int i = 0; i < int'(D); i++) m_mem[i] = '0;
        for (int i = 0; i < int'(NC); i++) begin
            s_tos[i]   = D - 1;
            s_depth[i] = 0;
            s_val[i]   = '0;
        end
    endtask

    task automatic check_regs();
        chk("depth", W'(depth), W'(m_depth));
        chk("full",  W'(full),  W'(m_depth == int'(D)));
        chk("empty", W'(empty), W'(m_depth == 0));
    endtask

    // Reset with push/pop asserted to show that reset takes priority
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        push         = 1'b1;
        pop          = 1'b1;
        push_din     = $urandom;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
        #1;
        chk("rst_hit",  W'(pop_hit), '0);
        chk("rst_dout", pop_dout, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        model_reset();
        check_regs();
    endtask

    // One clock of stimulus, checked before and after the edge
    task automatic step(input bit p, input logic [W-1:0] din, input bit q,
                        input bit sv, input logic [1:0] st,
                        input bit rs, input logic [1:0] rt);
        logic [W-1:0] e_dout;
        bit           e_hit;
        @(negedge clk);
        push             = p;
        push_din         = din;
        pop              = q;
        ckpt_save        = sv;
        ckpt_save_tag    = st;
        ckpt_restore     = rs;
        ckpt_restore_tag = rt;
        #1;
        e_hit  = 1'b0;
        e_dout = '0;
        if (!rs && q) begin
            if (m_depth > 0) begin
                e_hit  = 1'b1;
                e_dout = m_mem[m_tos];
            end else begin
                e_dout = LAST_POP ? m_last : '0;
            end
        end
        obs_dout = pop_dout;
        obs_hit  = pop_hit;
        chk("pop_hit",  W'(pop_hit), W'(e_hit));
        chk("pop_dout", pop_dout, e_dout);
        @(posedge clk);
        if (rs) begin
            m_tos   = s_tos[rt];
            m_depth = s_depth[rt];
            m_mem[m_tos] = s_val[rt];
        end else begin
            if (e_hit) m_last = e_dout;
            if (p && q && m_depth > 0) begin
                m_mem[m_tos] = din;
            end else if (p) begin
                m_tos = (m_tos + 1) % D;
                m_mem[m_tos] = din;
                if (m_depth < int'(D)) m_depth++;
            end else if (q && m_depth > 0) begin
                m_tos = (m_tos + D - 1) % D;
                m_depth--;
            end
            if (sv) begin
                s_tos[st]   = m_tos;
                s_depth[st] = m_depth;
                s_val[st]   = m_mem[m_tos];
            end
        end
        #1;
        push         = 1'b0;
        pop          = 1'b0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
        check_regs();
    endtask

    task automatic do_push(input logic [W-1:0] v);
        step(1'b1, v, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic do_pop();
        step(1'b0, '0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Push A,B,C then pop three times
        do_push(32'hA); do_push(32'hB); do_push(32'hC);
        do_pop(); chk("lifo_c", obs_dout, 32'hC); chk("lifo_c_hit", W'(obs_hit), 32'd1);
        do_pop(); chk("lifo_b", obs_dout, 32'hB);
        do_pop(); chk("lifo_a", obs_dout, 32'hA);
        chk("lifo_depth0", W'(depth), 32'd0);
        chk("lifo_empty",  W'(empty), 32'd1);

        // Overflow: oldest entries are overwritten, depth saturates
        do_reset();
        for (int i = 1; i <= 6; i++) do_push(W'(i));
        chk("ovf_depth", W'(depth), 32'd4);
        chk("ovf_full",  W'(full),  32'd1);
        for (int i = 6; i >= 3; i--) begin
            do_pop();
            chk("ovf_pop", obs_dout, W'(i));
        end

        // Empty pop after popping 0x40
        do_reset();
        do_push(32'h40);
        do_pop();
        do_pop();
        chk("emp_hit",  W'(obs_hit), 32'd0);
        chk("emp_dout", obs_dout, LAST_POP ? 32'h40 : 32'h0);

        // Simultaneous push and pop replaces the top
        do_reset();
        do_push(32'h10);
        step(1'b1, 32'h20, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("pp_dout",  obs_dout, 32'h10);
        chk("pp_depth", W'(depth), 32'd1);
        do_pop();
        chk("pp_next", obs_dout, 32'h20);

        // Checkpoint save and restore
        do_reset();
        do_push(32'h10);
        step(1'b0, '0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
        do_pop();
        do_push(32'h99);
        step(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2);
        chk("ck_depth", W'(depth), 32'd1);
        do_pop();
        chk("ck_pop", obs_dout, 32'h10);

        // Restore with push and pop; restoring a never-written slot empties the stack
        do_reset();
        do_push(32'h55); do_push(32'h66);
        step(1'b1, 32'h77, 1'b1, 1'b1, 2'd1, 1'b1, 2'd3);
        chk("rp_dout",  obs_dout, 32'h0);
        chk("rp_hit",   W'(obs_hit), 32'd0);
        chk("rp_depth", W'(depth), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 99) < 50), $urandom,
                     ($urandom_range(0, 99) < 45),
                     ($urandom_range(0, 99) < 20), 2'($urandom),
                     ($urandom_range(0, 99) < 8),  2'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
